// File: rtl/dmem_wait.sv
// dmem_wait: wait-state data RAM with valid/ready requests, RV32I byte/half/word lanes and error reporting
module dmem_wait #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d, acc, fire, op_we, err;
  logic [2:0] f3_q, f3_d, op_f3;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] op_addr, op_wdata, word, ld, wd;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic [31:0] mem_q [DEPTH];
  always_comb begin
    acc = req_valid && state_q != WAIT;
    state_d = acc ? (LATENCY > 0 ? WAIT : RESP) : state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_d = acc ? 4'(LATENCY > 0 ? LATENCY - 1 : 0) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    we_d = acc ? req_we : we_q;
    f3_d = acc ? req_funct3 : f3_q;
    addr_d = acc ? req_addr : addr_q;
    wdata_d = acc ? req_wdata : wdata_q;
    op_we = state_q == WAIT ? we_q : req_we;
    op_f3 = state_q == WAIT ? f3_q : req_funct3;
    op_addr = state_q == WAIT ? addr_q : req_addr;
    op_wdata = state_q == WAIT ? wdata_q : req_wdata;
    fire = state_d == RESP && !reset;
    idx = op_addr[AW+1:2];
    err = op_f3 == 3'b011 || op_f3[2:1] == 2'b11 || (op_we && op_f3[2]) ||
          (op_f3[1:0] == 2'b01 && op_addr[0]) || (op_f3[1:0] == 2'b10 && op_addr[1:0] != 2'b00) ||
          op_addr[31:2] >= 30'(DEPTH);
    word = mem_q[idx];
    lb = word[{op_addr[1:0], 3'b000} +: 8];
    lh = word[{op_addr[1], 4'b0000} +: 16];
    ld = op_f3[1] ? word : op_f3[0] ? {{16{~op_f3[2] & lh[15]}}, lh} : {{24{~op_f3[2] & lb[7]}}, lb};
    be = op_f3[1] ? 4'hF : op_f3[0] ? 4'(4'h3 << {op_addr[1], 1'b0}) : 4'(4'h1 << op_addr[1:0]);
    wd = op_wdata << {op_addr[1:0], 3'b000};
    rdata_d = fire && !op_we && !err ? ld : 32'd0;
    err_d = fire && err;
    req_ready = state_q != WAIT;
    busy = state_q == WAIT;
    resp_valid = state_q == RESP;
    resp_rdata = rdata_q;
    resp_err = err_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  always_ff @(posedge clk)
    if (fire && op_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: tb/tb_dmem_wait.sv
// tb_dmem_wait: three latency builds driven against a byte-level reference model with per-cycle output checks
module tb_dmem_wait;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic [2:0] rst, rv, rdy, we, rvld, rerr, bsy;
  logic [2:0] f3 [3];
  logic [31:0] addr [3], wdat [3], rdat [3];
  int ec = 0;
  int checks = 0, fails = 0;
  bit chk_en = 1'b0;
  bit pend [3], ev [3], ee [3], q_we [3];
  int hc [3];
  logic [31:0] ed [3], q_a [3], q_wd [3];
  logic [2:0] q_f3 [3];
  logic [7:0] mb [3][256];

  always #5 clk = ~clk;

  dmem_wait #(.DEPTH(DEPTH), .LATENCY(1)) u0 (.clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_we(we[0]), .req_funct3(f3[0]), .req_addr(addr[0]), .req_wdata(wdat[0]), .resp_valid(rvld[0]),
    .resp_rdata(rdat[0]), .resp_err(rerr[0]), .busy(bsy[0]));
  dmem_wait #(.DEPTH(DEPTH), .LATENCY(3)) u1 (.clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_we(we[1]), .req_funct3(f3[1]), .req_addr(addr[1]), .req_wdata(wdat[1]), .resp_valid(rvld[1]),
    .resp_rdata(rdat[1]), .resp_err(rerr[1]), .busy(bsy[1]));
  dmem_wait #(.DEPTH(DEPTH), .LATENCY(0)) u2 (.clk(clk), .reset(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_we(we[2]), .req_funct3(f3[2]), .req_addr(addr[2]), .req_wdata(wdat[2]), .resp_valid(rvld[2]),
    .resp_rdata(rdat[2]), .resp_err(rerr[2]), .busy(bsy[2]));

  function automatic int lat_of(input int i);
    return i == 0 ? 1 : i == 1 ? 3 : 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d(LATENCY=%0d) got=%h exp=%h t=%0t", nm, i, lat_of(i), act, exp, $time);
    end
  endtask

  // Reference: a request handshaken in cycle h answers in cycle h+LATENCY+1 and is busy in between.
  always @(posedge clk) begin
    ec <= ec + 1;
    for (int i = 0; i < 3; i++) begin
      automatic bit p = pend[i];
      automatic int h = hc[i];
      automatic bit lw = q_we[i];
      automatic logic [2:0] lf = q_f3[i];
      automatic logic [31:0] la = q_a[i];
      automatic logic [31:0] lwd = q_wd[i];
      automatic logic [31:0] d = 32'd0;
      automatic bit v = 1'b0;
      automatic bit e = 1'b0;
      automatic int sz;
      if (rst[i]) p = 1'b0;
      else begin
        if (rv[i] && !(p && ec > h)) begin
          p = 1'b1; h = ec; lw = we[i]; lf = f3[i]; la = addr[i]; lwd = wdat[i];
        end
        if (p && ec == h + lat_of(i)) begin
          p = 1'b0;
          v = 1'b1;
          sz = lf[1:0] == 2'd0 ? 1 : lf[1:0] == 2'd1 ? 2 : 4;
          e = lf == 3'd3 || lf >= 3'd6 || (lw && lf[2]) || la % sz != 0 || la / 4 >= DEPTH;
          if (!e && lw) begin
            for (int k = 0; k < sz; k++) mb[i][8'(la + k)] <= 8'(lwd >> (8 * k));
          end else if (!e) begin
            for (int k = 0; k < sz; k++) d = d | (32'(mb[i][8'(la + k)]) << (8 * k));
            if (!lf[2] && sz < 4 && d[8 * sz - 1]) d = d | (32'hFFFF_FFFF << (8 * sz));
          end
        end
      end
      pend[i] <= p; hc[i] <= h; ev[i] <= v; ed[i] <= d; ee[i] <= e;
      q_we[i] <= lw; q_f3[i] <= lf; q_a[i] <= la; q_wd[i] <= lwd;
    end
  end

  always @(negedge clk)
    if (chk_en)
      for (int i = 0; i < 3; i++) begin
        chk("resp_valid", i, 32'(rvld[i]), 32'(ev[i]));
        chk("resp_rdata", i, rdat[i], ed[i]);
        chk("resp_err", i, 32'(rerr[i]), 32'(ee[i]));
        chk("busy", i, 32'(bsy[i]), 32'(pend[i] && ec > hc[i]));
        chk("req_ready", i, 32'(rdy[i]), 32'(!(pend[i] && ec > hc[i])));
      end

  task automatic wait_sig(input int i, input bit resp, output int nb);
    int t = 0;
    nb = 0;
    do begin
      @(negedge clk);
      t++;
      nb += 32'(bsy[i]);
    end while (!(resp ? rvld[i] : rdy[i]) && t < 60);
    if (t >= 60) begin
      checks++;
      fails++;
      $display("FAIL %s inst%0d got=no_event exp=event_within_60_cycles", resp ? "resp_timeout" : "ready_timeout", i);
    end
  endtask

  task automatic txn(input int i, input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output bit er, output int lat, output int nb);
    int c, dummy;
    @(posedge clk); #1;
    rv[i] = 1'b1; we[i] = w; f3[i] = f; addr[i] = a; wdat[i] = wd;
    wait_sig(i, 1'b0, dummy);
    c = ec;
    @(posedge clk); #1;
    rv[i] = 1'b0;
    wait_sig(i, 1'b1, nb);
    lat = ec - c;
    rd = rdat[i];
    er = rerr[i];
  endtask

  task automatic dtx(input int i, input string nm, input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_er);
    logic [31:0] rd;
    bit er;
    int lat, nb;
    txn(i, w, f, a, wd, rd, er, lat, nb);
    chk({nm, "_rdata"}, i, rd, exp_rd);
    chk({nm, "_err"}, i, 32'(er), 32'(exp_er));
    chk({nm, "_latency"}, i, lat, lat_of(i) + 1);
    chk({nm, "_busy_cycles"}, i, nb, lat_of(i));
  endtask

  task automatic b2b(input int i);
    int c, nb;
    @(posedge clk); #1;
    rv[i] = 1'b1; we[i] = 1'b1; f3[i] = 3'd2; addr[i] = 32'h30; wdat[i] = 32'hA5A5A5A5;
    wait_sig(i, 1'b0, nb);
    @(posedge clk); #1;
    we[i] = 1'b0;
    wait_sig(i, 1'b1, nb);
    chk("b2b_sw_err", i, 32'(rerr[i]), 32'd0);
    chk("b2b_ready_in_resp", i, 32'(rdy[i]), 32'd1);
    c = ec;
    @(posedge clk); #1;
    rv[i] = 1'b0;
    wait_sig(i, 1'b1, nb);
    chk("b2b_lw_latency", i, ec - c, lat_of(i) + 1);
    chk("b2b_lw_rdata", i, rdat[i], 32'hA5A5A5A5);
  endtask

  task automatic rst_abort(input int i);
    int nb;
    @(posedge clk); #1;
    rv[i] = 1'b1; we[i] = 1'b1; f3[i] = 3'd2; addr[i] = 32'h40; wdat[i] = 32'h12345678;
    rst[i] = lat_of(i) == 0;
    wait_sig(i, 1'b0, nb);
    @(posedge clk); #1;
    rv[i] = 1'b0; rst[i] = 1'b1;
    @(posedge clk); #1;
    rst[i] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_resp", i, 32'(rvld[i]), 32'd0);
      chk("abort_ready", i, 32'(rdy[i]), 32'd1);
    end
    dtx(i, "abort_lw40", 1'b0, 3'd2, 32'h40, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic init_run(input int i);
    logic [31:0] rd;
    bit er;
    int lat, nb;
    for (int w = 0; w < DEPTH; w++) txn(i, 1'b1, 3'd2, 32'(w * 4), 32'd0, rd, er, lat, nb);
  endtask

  task automatic rand_run(input int i);
    logic [2:0] lds [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] rd, a;
    logic [2:0] f;
    bit er, w;
    int lat, nb, sz, j;
    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      w = 1'($urandom_range(0, 1));
      j = $urandom_range(0, 4);
      f = $urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 7)) : w ? 3'($urandom_range(0, 2)) : lds[j];
      sz = 1 << f[1:0];
      a = ($urandom_range(0, 1) == 0 ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, DEPTH + 3))) * 4
          + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      if ($urandom_range(0, 31) == 0) a = $urandom;
      txn(i, w, f, a, $urandom, rd, er, lat, nb);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = '1; rv = '0; we = '0;
    for (int i = 0; i < 3; i++) begin
      f3[i] = 3'd0; addr[i] = 32'd0; wdat[i] = 32'd0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = '0;
    fork
      init_run(0);
      init_run(1);
      init_run(2);
    join
    for (int i = 0; i < 3; i++) begin
      dtx(i, "sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      dtx(i, "lw10", 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
      dtx(i, "sw20", 1'b1, 3'd2, 32'h20, 32'h11223344, 32'd0, 1'b0);
      dtx(i, "sb21", 1'b1, 3'd0, 32'h21, 32'h12345680, 32'd0, 1'b0);
      dtx(i, "lb21", 1'b0, 3'd0, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0);
      dtx(i, "lbu21", 1'b0, 3'd4, 32'h21, 32'd0, 32'h00000080, 1'b0);
      dtx(i, "lw20", 1'b0, 3'd2, 32'h20, 32'd0, 32'h11228044, 1'b0);
      dtx(i, "sh12", 1'b1, 3'd1, 32'h12, 32'hFFFF8001, 32'd0, 1'b0);
      dtx(i, "lh12", 1'b0, 3'd1, 32'h12, 32'd0, 32'hFFFF8001, 1'b0);
      dtx(i, "lhu12", 1'b0, 3'd5, 32'h12, 32'd0, 32'h00008001, 1'b0);
      dtx(i, "lw10b", 1'b0, 3'd2, 32'h10, 32'd0, 32'h8001BEEF, 1'b0);
      dtx(i, "lh13_mis", 1'b0, 3'd1, 32'h13, 32'd0, 32'd0, 1'b1);
      dtx(i, "sw22_mis", 1'b1, 3'd2, 32'h22, 32'hCAFEBABE, 32'd0, 1'b1);
      dtx(i, "lw_oor", 1'b0, 3'd2, 32'(4 * DEPTH), 32'd0, 32'd0, 1'b1);
      dtx(i, "f3_011", 1'b0, 3'd3, 32'h20, 32'd0, 32'd0, 1'b1);
      dtx(i, "st_f3_100", 1'b1, 3'd4, 32'h20, 32'hFFFFFFFF, 32'd0, 1'b1);
      dtx(i, "lw20_after_err", 1'b0, 3'd2, 32'h20, 32'd0, 32'h11228044, 1'b0);
      dtx(i, "sw_last", 1'b1, 3'd2, 32'(4 * DEPTH - 4), 32'hCAFEF00D, 32'd0, 1'b0);
      dtx(i, "lw_last", 1'b0, 3'd2, 32'(4 * DEPTH - 4), 32'd0, 32'hCAFEF00D, 1'b0);
      b2b(i);
      rst_abort(i);
    end
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dmem_wait.md
Name: dmem_wait

Overview:
- Parametrised successor to the single-cycle data memory: a synchronous data RAM with a configurable wait-state latency and a valid/ready request handshake.
- Supports RV32I byte, halfword and word loads and stores using funct3 encoding, with little-endian lane steering and load sign/zero extension.
- Detects misaligned, out-of-range and illegal accesses and reports them as errors.
- Sits between the core's load/store path and the data array, in place of the combinational-read data memory, for multicycle and stall-capable cores.

Parameters:
- DEPTH, 64, number of 32-bit words; legal word index is 0..DEPTH-1.
- LATENCY, 1, extra wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access error, qualified by resp_valid
- busy  out  1  a transaction is pending (WAIT state)

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE, wait counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, busy 0. Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we, funct3, addr and wdata. Go to WAIT if LATENCY>0 (counter loaded with LATENCY-1), otherwise go to RESP.
  - WAIT: req_ready=0, busy=1. Decrement the counter each cycle; at 0 go to RESP.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=1. A request accepted in RESP behaves as if accepted in IDLE (back-to-back). Otherwise return to IDLE.
- Latency: resp_valid is high in the cycle that begins LATENCY+1 clock edges after the acceptance edge.
- No response backpressure; the requester must take the response in the RESP cycle.
- Memory commit and read sample happen on the edge entering RESP. A load in RESP sees every store whose RESP came earlier.
- Word index is addr[31:2]; byte lane is addr[1:0], little-endian.
- Stores:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Untouched lanes are preserved.
- Loads:
  - The selected byte or half is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- Error conditions (set resp_err=1):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH.
  - Illegal funct3: any of 011, 110, 111; or a store with funct3[2]=1.
- On error: same latency as a normal access, no array write, resp_rdata=0.
- resp_rdata and resp_err are held at 0 outside RESP.
- Reset in IDLE or WAIT aborts the pending transaction: no write, no response, next cycle is IDLE with req_ready=1. Reset asserted in the RESP cycle still lets that cycle's commit stand, because the commit happened on the entry edge.
- req_valid asserted while req_ready=0 is ignored; the requester holds the request.

Test Plan:
- LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store resp_err=0, rdata=0; load rdata=0xDEADBEEF, resp_valid exactly 2 edges after each acceptance.
- SB 0x80 at 0x21, then LB 0x21 / LBU 0x21 / LW 0x20 -> 0xFFFFFF80 / 0x00000080 / word with [15:8]=0x80 and other lanes unchanged from the prior SW 0x20 0x11223344, i.e. 0x11228044.
- LH 0x13, SW 0x22, LW 4*DEPTH, funct3=011 -> each gives resp_err=1, rdata=0; a following LW 0x20 shows memory unchanged.
- LATENCY=3 and LATENCY=0 builds:
  - resp_valid in the cycle 4 (resp. 1) edges after acceptance;
  - busy high for 3 (resp. 0) cycles;
  - req_ready low during WAIT.
- Back-to-back: hold req_valid with SW 0x30 0xA5A5A5A5 then LW 0x30 -> second request accepted in the first RESP cycle; load returns 0xA5A5A5A5.
- SW 0x40 0x12345678 then reset in the WAIT cycle -> no resp_valid; after reset, the LW 0x40 response differs from 0x12345678 (location pre-written with 0 before the test).
